// File: rtl/timer_irq_bank.sv
// timer_irq_bank: CHANNELS down-counters sharing one prescaler, on the picorv32 native bus.
// Optional build macro TIMER_PWM_EN adds per-channel COMPARE registers and PWM outputs.
module timer_irq_bank #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 32,
  parameter int PRESCALER_BITS = 16,
  parameter int ADDR_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 sel,
  input  logic                 mem_valid,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic [CHANNELS-1:0]  irq,
  input  logic [CHANNELS-1:0]  eoi,
  output logic [CHANNELS-1:0]  pwm
);

  localparam int WB = ADDR_BITS - 2;

  logic [PRESCALER_BITS-1:0] prescale_q;
  logic [PRESCALER_BITS-1:0] pc_q;
  logic                      tick;

  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] oneshot_q;
  logic [CHANNELS-1:0] ie_q;
  logic [CHANNELS-1:0] pending_q;
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];

  logic                access;
  logic                wr;
  logic [WB-1:0]       widx;
  logic [31:0]         rd_data;
  logic                hit_prescale;
  logic                hit_status;
  logic [CHANNELS-1:0] hit_ctrl;
  logic [CHANNELS-1:0] hit_reload;
  logic [CHANNELS-1:0] hit_count;
  logic [CHANNELS-1:0] hit_cmp;
  logic [CHANNELS-1:0] expire;
  logic [CHANNELS-1:0] clear;
  logic                unused_addr_bits;

  function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [PRESCALER_BITS-1:0] merge_p(input logic [PRESCALER_BITS-1:0] old,
                                                       input logic [31:0] wd,
                                                       input logic [3:0] strb);
    logic [31:0] r;
    r = '0;
    r[PRESCALER_BITS-1:0] = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r[PRESCALER_BITS-1:0];
  endfunction

  assign access           = mem_valid & sel & ~mem_ready;
  assign wr               = access & (|mem_wstrb);
  assign widx             = mem_addr[ADDR_BITS-1:2];
  assign tick             = (pc_q == prescale_q);
  assign irq              = pending_q & ie_q;
  assign unused_addr_bits = ^mem_addr[1:0];

`ifdef TIMER_PWM_EN
  logic [WIDTH-1:0] compare_q [CHANNELS];
`endif

  // Word decode and read mux; anything not matched reads back as zero.
  always_comb begin
    hit_prescale = (widx == WB'(0));
    hit_status   = (widx == WB'(1));
    hit_ctrl     = '0;
    hit_reload   = '0;
    hit_count    = '0;
    hit_cmp      = '0;
    rd_data      = '0;
    if (hit_prescale) rd_data[PRESCALER_BITS-1:0] = prescale_q;
    if (hit_status)   rd_data[CHANNELS-1:0] = pending_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      hit_ctrl[ch]   = (widx == WB'(4*(ch+1)));
      hit_reload[ch] = (widx == WB'(4*(ch+1) + 1));
      hit_count[ch]  = (widx == WB'(4*(ch+1) + 2));
      hit_cmp[ch]    = (widx == WB'(4*(ch+1) + 3));
      if (hit_ctrl[ch])   rd_data = {29'd0, ie_q[ch], oneshot_q[ch], en_q[ch]};
      if (hit_reload[ch]) rd_data[WIDTH-1:0] = reload_q[ch];
      if (hit_count[ch])  rd_data[WIDTH-1:0] = count_q[ch];
`ifdef TIMER_PWM_EN
      if (hit_cmp[ch])    rd_data[WIDTH-1:0] = compare_q[ch];
`endif
    end
  end

  // Expiry sets pending; W1C and eoi clear it, but a same-cycle expiry wins.
  always_comb begin
    expire = '0;
    clear  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      expire[ch] = tick & en_q[ch] & (count_q[ch] == '0);
      clear[ch]  = eoi[ch] | (wr & hit_status & mem_wstrb[ch/8] & mem_wdata[ch]);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= access;
      if (access) mem_rdata <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prescale_q <= '0;
      pc_q       <= '0;
    end else if (wr && hit_prescale) begin
      prescale_q <= merge_p(prescale_q, mem_wdata, mem_wstrb);
      pc_q       <= '0;
    end else if (tick) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + PRESCALER_BITS'(1);
    end
  end

  // A bus write to COUNT or CTRL overrides whatever the tick would have done this cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      en_q      <= '0;
      oneshot_q <= '0;
      ie_q      <= '0;
      pending_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        reload_q[ch] <= '0;
        count_q[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (wr && hit_count[ch]) begin
          count_q[ch] <= merge_w(count_q[ch], mem_wdata, mem_wstrb);
        end else if (tick && en_q[ch]) begin
          if (count_q[ch] != '0) count_q[ch] <= count_q[ch] - WIDTH'(1);
          else if (!oneshot_q[ch]) count_q[ch] <= reload_q[ch];
        end

        if (wr && hit_ctrl[ch] && mem_wstrb[0]) begin
          en_q[ch]      <= mem_wdata[0];
          oneshot_q[ch] <= mem_wdata[1];
          ie_q[ch]      <= mem_wdata[2];
        end else if (expire[ch] && oneshot_q[ch]) begin
          en_q[ch] <= 1'b0;
        end

        if (wr && hit_reload[ch]) reload_q[ch] <= merge_w(reload_q[ch], mem_wdata, mem_wstrb);

        if (expire[ch])     pending_q[ch] <= 1'b1;
        else if (clear[ch]) pending_q[ch] <= 1'b0;
      end
    end
  end

`ifdef TIMER_PWM_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pwm <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) compare_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        pwm[ch] <= en_q[ch] & (count_q[ch] < compare_q[ch]);
        if (wr && hit_cmp[ch]) compare_q[ch] <= merge_w(compare_q[ch], mem_wdata, mem_wstrb);
      end
    end
  end
`else
  logic unused_cmp;
  assign unused_cmp = |hit_cmp;
  assign pwm        = '0;
`endif

endmodule

// File: tb/tb_timer_irq_bank.sv
// tb_timer_irq_bank: directed scenario tasks for timer_irq_bank with hand-computed expectations.
// Bus driven and outputs sampled on the falling edge; DUT registers on the rising edge.
module tb_timer_irq_bank;

  localparam int CH = 4;

  logic          clk       = 1'b0;
  logic          nreset    = 1'b0;
  logic          sel       = 1'b0;
  logic          mem_valid = 1'b0;
  logic [7:0]    mem_addr  = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [CH-1:0] irq;
  logic [CH-1:0] eoi       = '0;
  logic [CH-1:0] pwm;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  timer_irq_bank dut (
    .clk       (clk),
    .nreset    (nreset),
    .sel       (sel),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .irq       (irq),
    .eoi       (eoi),
    .pwm       (pwm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called on a falling edge; returns on the falling edge right after the acknowledge.
  task automatic bus_access(input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd);
    int n;
    sel = 1'b1; mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 10);
    if (!mem_ready) begin
      checks++; failures++;
      $display("[TB] FAIL bus_timeout addr=%h ready=%b required=1", addr, mem_ready);
    end
    rd = mem_rdata;
    sel = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_access(addr, wd, strb, dummy);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] rd);
    bus_access(addr, 32'h0, 4'h0, rd);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_ready, mem_rdata, irq, pwm} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ready=%b rdata=%h irq=%b pwm=%b required all 0",
               mem_ready, mem_rdata, irq, pwm);
    end
    nreset = 1'b1;
    @(negedge clk);
    for (int a = 0; a <= 'h50; a += 4) begin
      bus_read(8'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_read addr=%h got=%h required=0", a, rd);
      end
    end
    checks++;
    if (irq !== '0 || pwm !== '0) begin
      failures++;
      $display("[TB] FAIL reset_irq_pwm got irq=%b pwm=%b required 0", irq, pwm);
    end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    sel = 1'b1; mem_valid = 1'b1; mem_addr = 8'h08; mem_wstrb = 4'h0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hs_ready_first got=%b required=1", mem_ready);
    end
    checks++;
    if (mem_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL hs_rdata got=%h required=0", mem_rdata);
    end
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hs_no_back_to_back got=%b required=0", mem_ready);
    end
    sel = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hs_idle got=%b required=0", mem_ready);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] rd;
    int n, t1, t2;
    bus_write(8'h00, 32'd3, 4'hF);
    bus_write(8'h14, 32'd4, 4'hF);
    bus_write(8'h10, 32'h5, 4'hF);
    n = 0;
    while (!irq[0] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!irq[0]) begin
      failures++;
      $display("[TB] FAIL periodic_first_irq got=%b required=1", irq[0]);
    end
    t1 = cyc;
    bus_read(8'h04, rd);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("[TB] FAIL periodic_status got=%h required=1", rd);
    end
    bus_write(8'h04, 32'h1, 4'h1);
    checks++;
    if (irq[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL periodic_w1c_drop got=%b required=0", irq[0]);
    end
    n = 0;
    while (!irq[0] && n < 100) begin @(negedge clk); n++; end
    t2 = cyc;
    checks++;
    if (!irq[0] || (t2 - t1) != 20) begin
      failures++;
      $display("[TB] FAIL periodic_period got irq=%b cycles=%0d required irq=1 cycles=20", irq[0], t2 - t1);
    end
    bus_write(8'h10, 32'h0, 4'hF);
    bus_write(8'h04, 32'h1, 4'hF);
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    bus_write(8'h00, 32'd0, 4'hF);
    bus_write(8'h28, 32'd2, 4'hF);
    bus_write(8'h20, 32'h7, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (irq[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oneshot_early got=%b required=0", irq[1]);
    end
    @(negedge clk);
    checks++;
    if (irq[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oneshot_irq got=%b required=1", irq[1]);
    end
    bus_read(8'h20, rd);
    checks++;
    if (rd !== 32'h6) begin
      failures++;
      $display("[TB] FAIL oneshot_ctrl got=%h required=6", rd);
    end
    bus_read(8'h28, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL oneshot_count got=%h required=0", rd);
    end
    bus_write(8'h04, 32'h2, 4'h1);
    repeat (10) @(negedge clk);
    bus_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0 || irq !== '0) begin
      failures++;
      $display("[TB] FAIL oneshot_no_rearm got status=%h irq=%b required status=0 irq=0", rd, irq);
    end
  endtask

  task automatic test_irq_mask();
    logic [31:0] rd;
    bus_write(8'h34, 32'd3, 4'hF);
    bus_write(8'h30, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    bus_read(8'h04, rd);
    checks++;
    if (rd !== 32'h4) begin
      failures++;
      $display("[TB] FAIL mask_pending got=%h required=4", rd);
    end
    checks++;
    if (irq !== '0) begin
      failures++;
      $display("[TB] FAIL mask_irq got=%b required=0000", irq);
    end
    bus_write(8'h30, 32'h0, 4'hF);
    bus_write(8'h04, 32'h4, 4'h1);
    bus_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mask_w1c got=%h required=0", rd);
    end
  endtask

  task automatic test_eoi();
    bus_write(8'h14, 32'd9, 4'hF);
    bus_write(8'h18, 32'd2, 4'hF);
    bus_write(8'h10, 32'h5, 4'hF);
    repeat (2) @(negedge clk);
    eoi = 4'b0001;
    @(negedge clk);
    checks++;
    if (irq[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL eoi_same_cycle got=%b required=1", irq[0]);
    end
    @(negedge clk);
    eoi = 4'b0000;
    checks++;
    if (irq[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL eoi_clear got=%b required=0", irq[0]);
    end
    bus_write(8'h10, 32'h0, 4'hF);
    bus_write(8'h04, 32'hF, 4'h1);
  endtask

  task automatic test_count_write_tick();
    logic [31:0] rd;
    bus_write(8'h48, 32'hAABBCC80, 4'hF);
    bus_write(8'h40, 32'h1, 4'hF);
    bus_write(8'h00, 32'd7, 4'hF);
    repeat (7) @(negedge clk);
    bus_write(8'h48, 32'h55667710, 4'h1);
    bus_read(8'h48, rd);
    checks++;
    if (rd !== 32'hAABBCC10) begin
      failures++;
      $display("[TB] FAIL count_write_wins got=%h required=aabbcc10", rd);
    end
    repeat (7) @(negedge clk);
    bus_read(8'h48, rd);
    checks++;
    if (rd !== 32'hAABBCC0F) begin
      failures++;
      $display("[TB] FAIL count_decrement got=%h required=aabbcc0f", rd);
    end
    bus_write(8'h40, 32'h0, 4'hF);
    bus_write(8'h04, 32'hF, 4'h1);
  endtask

  task automatic test_pwm();
    logic [31:0] rd;
    logic [31:0] cmp_wr, cmp_rd;
    int highs, exp_highs;
`ifdef TIMER_PWM_EN
    cmp_wr = 32'd3; cmp_rd = 32'd3; exp_highs = 6;
`else
    cmp_wr = 32'd5; cmp_rd = 32'd0; exp_highs = 0;
`endif
    bus_write(8'h00, 32'd0, 4'hF);
    bus_write(8'h1C, cmp_wr, 4'hF);
    bus_write(8'h14, 32'd9, 4'hF);
    bus_write(8'h18, 32'd9, 4'hF);
    bus_write(8'h10, 32'h1, 4'hF);
    bus_read(8'h1C, rd);
    checks++;
    if (rd !== cmp_rd) begin
      failures++;
      $display("[TB] FAIL pwm_compare_read got=%h required=%h", rd, cmp_rd);
    end
    repeat (5) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm[0] === 1'b1) highs++;
    end
    checks++;
    if (highs != exp_highs) begin
      failures++;
      $display("[TB] FAIL pwm_duty got=%0d high cycles of 20 required=%0d", highs, exp_highs);
    end
    bus_write(8'h10, 32'h0, 4'hF);
    bus_write(8'h04, 32'hF, 4'h1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout at cycle %0d required completion", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_handshake();
    test_periodic();
    test_oneshot();
    test_irq_mask();
    test_eoi();
    test_count_write_tick();
    test_pwm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
